// File: rtl/gray_dec_arbiter_if.sv
// Request/response bundle between NREQ requesters and gray_dec_arbiter.
//   req_valid[NREQ]   requester -> arbiter, per-requester request valid
//   req_gray[4*NREQ]  requester -> arbiter, Gray word of requester i in [4i+3:4i]
//   req_ready[NREQ]   arbiter -> requester, one-hot accept strobe
//   rsp_valid[NREQ]   arbiter -> requester, one-hot response valid to the owner
//   rsp_ready[NREQ]   requester -> arbiter, per-requester response ready
//   rsp_bin[4]        arbiter -> requester, decoded binary result (shared)
//   rsp_err           arbiter -> requester, self-check mismatch flag
// Modports: master = requester side, slave = arbiter side.
interface gray_dec_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_gray;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [3:0]        rsp_bin;
    logic              rsp_err;

    modport master (
        output req_valid, req_gray, rsp_ready,
        input  req_ready, rsp_valid, rsp_bin, rsp_err
    );

    modport slave (
        input  req_valid, req_gray, rsp_ready,
        output req_ready, rsp_valid, rsp_bin, rsp_err
    );
endinterface

// File: rtl/gray_dec_arbiter.sv
// Round-robin arbiter sharing one 4-bit Gray-to-binary decoder among NREQ requesters.
// A winner's Gray word is latched and driven to the decoder for DEC_LAT cycles, the binary
// result is captured and returned to the owner over a valid/ready response.
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   bus          gray_dec_arbiter_if.slave request/response bundle
//   dec_gray_o   Gray word driven to the shared decoder (registered)
//   dec_bin_i    binary result from the shared decoder
//   busy         high whenever the FSM is not idle
// Optional: define GRAY_DEC_SELFCHECK_EN to re-encode the decoder result at capture and
// flag a mismatch against the driven word on rsp_err; otherwise rsp_err is tied low.
module gray_dec_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DEC_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    gray_dec_arbiter_if.slave bus,
    output logic [3:0]        dec_gray_o,
    input  logic [3:0]        dec_bin_i,
    output logic              busy
);
    localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] gnt_q, gnt_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [3:0]      gray_q, gray_d;
    logic [3:0]      bin_q, bin_d;
    logic            capture;

    logic            found;
    logic [PtrW-1:0] win;
    logic [PtrW-1:0] idx;
    logic [3:0]      win_gray;
    logic            owner_ready;

    // Round-robin search starting at ptr_q; first valid requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = PtrW'((32'(ptr_q) + k) % NREQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        win_gray      = '0;
        owner_ready   = 1'b0;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (PtrW'(i) == win) begin
                win_gray = bus.req_gray[4*i +: 4];
            end
            if (PtrW'(i) == gnt_q) begin
                owner_ready = bus.rsp_ready[i];
            end
            bus.req_ready[i] = (state_q == StIdle) && found && (PtrW'(i) == win);
            bus.rsp_valid[i] = (state_q == StResp) && (PtrW'(i) == gnt_q);
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gray_d  = gray_q;
        bin_d   = bin_q;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (found) begin
                    gnt_d   = win;
                    gray_d  = win_gray;
                    cnt_d   = 4'(DEC_LAT);
                    state_d = StDrive;
                end
            end
            StDrive: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    capture = 1'b1;
                    bin_d   = dec_bin_i;
                    state_d = StResp;
                end
            end
            StResp: begin
                // Only the owner's ready completes the response.
                if (owner_ready) begin
                    ptr_d   = (gnt_q == PtrW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gray_q  <= '0;
            bin_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gray_q  <= gray_d;
            bin_q   <= bin_d;
        end
    end

`ifdef GRAY_DEC_SELFCHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (capture) begin
            err_d = ((dec_bin_i ^ (dec_bin_i >> 1)) != gray_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.rsp_err = err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    // Decoder input stays on the last latched word in every state.
    assign dec_gray_o  = gray_q;
    assign bus.rsp_bin = bin_q;
    assign busy        = (state_q != StIdle);
endmodule

// File: doc/gray_dec_arbiter.md
Name: gray_dec_arbiter

Overview:
- Shares one 4-bit Gray-to-binary decoder instance among NREQ requesters.
- Each requester hands over a 4-bit Gray word through a valid/ready handshake. The block arbitrates round-robin, drives the shared decoder, and waits a fixed decoder latency. It captures the binary result and returns it to the owning requester through a valid/ready response.
- Sits between switch/Hamming front-end logic and the single decoder on the Tang 9k board.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- DEC_LAT, 1, cycles from dec_gray_o stable to dec_bin_i valid; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_gray  in  4*NREQ  Gray words; requester i uses bits [4i+3:4i], bit 3 = MSB.
- req_ready  out  NREQ  one-hot accept strobe.
- rsp_valid  out  NREQ  one-hot response valid to the owner.
- rsp_ready  in  NREQ  per-requester response ready.
- rsp_bin  out  4  decoded binary result, shared by all requesters.
- rsp_err  out  1  self-check mismatch flag (see Optional Feature).
- dec_gray_o  out  4  drive to the shared decoder input.
- dec_bin_i  in  4  shared decoder output.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, gnt_q=0, ptr=0, cnt=0, gray_q=0.
  - All outputs 0: req_ready, rsp_valid, rsp_bin, rsp_err, dec_gray_o, busy.
- FSM states:
  - IDLE:
    - Winner = first i with req_valid[i]=1, searching from ptr upward modulo NREQ.
    - req_ready[winner]=1 combinationally in the same cycle; handshake completes that cycle.
    - Latch gray_q <= winner's word and gnt_q <= winner; cnt <= DEC_LAT; go to DRIVE.
    - No valid request: stay in IDLE; req_ready all 0.
  - DRIVE:
    - dec_gray_o = gray_q (registered); cnt decrements each cycle.
    - When cnt reaches 1: rsp_bin <= dec_bin_i, compute rsp_err; go to RESP.
    - Dwell in DRIVE = DEC_LAT cycles.
  - RESP:
    - rsp_valid[gnt_q]=1, other rsp_valid bits 0; rsp_bin held stable.
    - On rsp_ready[gnt_q]=1: ptr <= (gnt_q+1) mod NREQ; go to IDLE.
    - rsp_ready bits of non-owners are ignored.
- Latency and throughput:
  - Accept to rsp_valid = DEC_LAT+1 cycles.
  - Back-to-back minimum = DEC_LAT+2 cycles per transaction when rsp_ready is tied high.
- req_ready is 0 in DRIVE and RESP. Requests arriving there wait; a requester may hold req_valid indefinitely.
- A requester dropping req_valid before being granted is legal and has no side effect. req_gray of a non-winner is don't-care.
- Fairness: after serving i, requester i has lowest priority. With all requesters valid, the grant sequence is 0,1,2,...,NREQ-1,0.
- dec_gray_o holds gray_q in all states (avoids decoder toggling). rsp_bin holds its last value after the response.
- Reset asserted mid-transaction: transaction is dropped silently, no response is issued, and ptr returns to 0.
- busy = (state != IDLE).

Optional Feature:
- Macro GRAY_DEC_SELFCHECK_EN.
- Defined:
  - At capture, re-encode dec_bin_i ^ (dec_bin_i >> 1) and compare with gray_q.
  - rsp_err = 1 on mismatch; it is valid alongside rsp_valid and held with rsp_bin.
- Undefined: rsp_err is tied to 0 and no comparator is built.

Test Plan:
- Reset mid-DRIVE (req 1, gray 4'b0110, rst_n low for 1 cycle) -> no rsp_valid; all outputs 0 after reset; next simultaneous req 0 and req 1 grants req 0.
- Single request, DEC_LAT=1, req 2 gray 4'b1000, ideal decoder model, rsp_ready high -> req_ready=4'b0100 in cycle 0; rsp_valid=4'b0100 and rsp_bin=4'b1111 in cycle 2.
- All four requesters valid continuously, grays 4'b0000/4'b0001/4'b0011/4'b1100 -> grant order 0,1,2,3,0; rsp_bin 0000, 0001, 0010, 1000 respectively.
- Response backpressure: rsp_ready low for 5 cycles -> rsp_valid and rsp_bin stable throughout, req_ready stays 0, busy=1; completes on the first rsp_ready high.
- DEC_LAT=3, req 0 gray 4'b0110 -> DRIVE lasts exactly 3 cycles, rsp_bin=4'b0100 appears 4 cycles after accept.
- With GRAY_DEC_SELFCHECK_EN, decoder model faulted to return 4'b0101 for gray 4'b0110 -> rsp_err=1 with rsp_valid. Without the macro -> rsp_err=0.
